// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubbles, branch squash,
// EX forwarding selects, multi-cycle data-memory wait sequencing with timeout fault.

module phc_fwd_sel (
  input  logic       en,
  input  logic [4:0] src,
  input  logic       reg_write_m,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_w,
  input  logic [4:0] write_reg_w,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (en) begin
      // MEM holds the younger result, so it wins over WB
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == src)
        sel = 2'b10;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == src)
        sel = 2'b01;
    end
  end
endmodule

module phc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      cnt <= '0;
    else if (inc && cnt != {W{1'b1}})
      cnt <= cnt + 1'b1;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [4:0]       Ra_D,
  input  logic [4:0]       Rb_D,
  input  logic             UsesRb_D,
  input  logic [4:0]       Ra_E,
  input  logic [4:0]       Rb_E,
  input  logic             RegWrite_E,
  input  logic             MemRead_E,
  input  logic [4:0]       WriteReg_E,
  input  logic             BranchTaken_E,
  input  logic             RegWrite_M,
  input  logic [4:0]       WriteReg_M,
  input  logic             MemAccess_M,
  input  logic             mem_ready,
  input  logic             RegWrite_W,
  input  logic [4:0]       WriteReg_W,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       FwdA_E,
  output logic [1:0]       FwdB_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]        state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              mem_hold, load_use;

  assign mem_hold = MemAccess_M & ~mem_ready;
  assign load_use = RegWrite_E & MemRead_E & (WriteReg_E != 5'd0) &
                    ((WriteReg_E == Ra_D) | (UsesRb_D & (WriteReg_E == Rb_D)));

  // Outputs are gated by clr_n so nothing stale leaks out while reset is held
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (clr_n) begin
      if (state == ST_FAULT || mem_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (BranchTaken_E) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_hold) begin
            state    <= ST_WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!mem_hold) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state   <= ST_FAULT;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          state   <= ST_FAULT;
          mem_err <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Operand 0 is A (Ra_E), operand 1 is B (Rb_E)
  logic [1:0][4:0] fwd_src;
  logic [1:0][1:0] fwd_sel;

  assign fwd_src = {Rb_E, Ra_E};
  assign FwdA_E  = fwd_sel[0];
  assign FwdB_E  = fwd_sel[1];

  generate
    for (genvar i = 0; i < 2; i++) begin : g_fwd
      phc_fwd_sel u_fwd (
        .en          (clr_n),
        .src         (fwd_src[i]),
        .reg_write_m (RegWrite_M),
        .write_reg_m (WriteReg_M),
        .reg_write_w (RegWrite_W),
        .write_reg_w (WriteReg_W),
        .sel         (fwd_sel[i])
      );
    end
  endgenerate

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc      = {FlushE & BranchTaken_E, StallF};
  assign stall_cycles = cnt_val[0];
  assign flush_count  = cnt_val[1];

  generate
    for (genvar i = 0; i < 2; i++) begin : g_cnt
      phc_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (cnt_inc[i]),
        .cnt   (cnt_val[i])
      );
    end
  endgenerate

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It watches decode, execute, memory and writeback stage register fields and drives the stall/clear controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the EX-stage forwarding mux selects and sequences multi-cycle data-memory waits, with a timeout fault. Saturating performance counters record stall cycles and branch flushes.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum number of MEM_WAIT cycles before the block enters FAULT.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- Ra_D, Rb_D  in  5 each  source register numbers of the instruction in decode.
- UsesRb_D  in  1  decode instruction reads Rb.
- Ra_E, Rb_E  in  5 each  source register numbers held in ID/EX.
- RegWrite_E, MemRead_E  in  1 each  execute-stage controls.
- WriteReg_E  in  5  execute-stage destination register, after RegDst selection.
- BranchTaken_E  in  1  branch/jump resolved taken in EX.
- RegWrite_M  in  1  memory-stage write enable.
- WriteReg_M  in  5  memory-stage destination register.
- MemAccess_M  in  1  memory stage performs a load or store.
- mem_ready  in  1  data memory has completed the access this cycle.
- RegWrite_W  in  1  writeback-stage write enable.
- WriteReg_W  in  5  writeback-stage destination register.
- StallF, StallD, StallE, StallM  out  1 each  hold PC, IF/ID, ID/EX, EX/MEM respectively.
- FlushD, FlushE, FlushW  out  1 each  synchronous clear into IF/ID, ID/EX, MEM/WB.
- FwdA_E, FwdB_E  out  2 each  forwarding selects: 00 register file, 10 from MEM, 01 from WB.
- mem_err  out  1  sticky memory timeout fault.
- stall_cycles, flush_count  out  CNT_W each  saturating performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- **mem_hold** = MemAccess_M & !mem_ready.
- **load_use** = RegWrite_E & MemRead_E & (WriteReg_E != 0) & ((WriteReg_E == Ra_D) | (UsesRb_D & (WriteReg_E == Rb_D))).
- Output priority, evaluated in RUN and in MEM_WAIT:
  1. mem_hold: StallF, StallD, StallE, StallM = 1 and FlushW = 1. All other actions are suppressed, and branch or load-use is re-evaluated once the hold ends.
  2. else BranchTaken_E: FlushD = 1 and FlushE = 1, with no stalls. A concurrent load_use is ignored because the decode instruction is squashed.
  3. else load_use: StallF = 1, StallD = 1, FlushE = 1 (bubble into ID/EX).
  4. else all stall and flush outputs are 0.
- RUN to MEM_WAIT when mem_hold; wait counter loads 1.
- In MEM_WAIT:
  - mem_ready = 1: return to RUN. Outputs that cycle follow the priority list with mem_hold false, so the pipeline advances.
  - mem_ready = 0: wait counter increments.
  - wait counter == MEM_TIMEOUT with mem_ready = 0: go to FAULT.
- FAULT:
  - StallF, StallD, StallE, StallM and FlushW are held at 1; FlushD and FlushE are 0.
  - mem_err = 1.
  - Exit only through reset.
- Forwarding (combinational, independent of FSM state), FwdA_E:
  - 10 if RegWrite_M & WriteReg_M != 0 & WriteReg_M == Ra_E;
  - else 01 if RegWrite_W & WriteReg_W != 0 & WriteReg_W == Ra_E;
  - else 00.
  - MEM has priority over WB. FwdB_E is identical using Rb_E.
- stall_cycles increments on every clock with StallF = 1; flush_count increments on every clock with FlushE & BranchTaken_E. Both saturate at all-ones and never wrap.

## Timing
- Reset (clr_n low, asynchronous): state = RUN, wait counter = 0, mem_err = 0, both counters = 0.
- While clr_n is low, every stall, flush and forwarding output is forced to 0.
- Stall, flush and forwarding outputs are combinational from the current state and inputs, valid in the same cycle. State, counters and mem_err update on the rising edge of clk.
- Load-use penalty: exactly 1 bubble cycle. On the next edge, the load moves to MEM and load_use falls unless re-triggered.
- Taken-branch penalty: 2 squashed instructions (IF/ID and ID/EX cleared on one edge).
- Memory wait: stalls are asserted for every cycle mem_ready = 0; the stage register advances on the first edge where mem_ready = 1.
- A reset asserted mid-MEM_WAIT or in FAULT returns to RUN immediately, with no stale stall.

## Test plan
- **Load-use:** lw $8 in EX (MemRead_E = 1, RegWrite_E = 1, WriteReg_E = 8), Ra_D = 8 -> StallF = StallD = FlushE = 1 for one cycle; stall_cycles = 1. Repeat with WriteReg_E = 0 -> no stall.
- **Branch wins:** BranchTaken_E = 1 with load_use also true -> FlushD = FlushE = 1, StallF = 0, flush_count = 1.
- **Forwarding:** WriteReg_M = WriteReg_W = 5, both RegWrite = 1, Ra_E = 5 -> FwdA_E = 10. Drop RegWrite_M -> FwdA_E = 01. Set WriteReg_W = 0 -> FwdA_E = 00.
- **Memory wait:** MemAccess_M = 1, mem_ready low for 3 cycles then high -> all four stalls and FlushW = 1 for 3 cycles, 0 on cycle 4; state back to RUN.
- **Timeout:** MEM_TIMEOUT = 4, mem_ready held low -> FAULT after 4 wait cycles, mem_err = 1 and stalls stuck. Assert clr_n = 0 -> all outputs 0, state RUN.
- **Saturation:** CNT_W = 4, force 20 stall cycles -> stall_cycles holds at 15.
